// File: rtl/control_unit_risc.sv
// Multi-cycle control sequencer for a 16-bit RISC datapath: fetch, decode, execute, load/store, halt.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes set illegal_op and enter HALT instead of acting as NOP.
module control_unit_risc #(
    parameter int unsigned word_size = 16,
    parameter int unsigned op_size   = 5,
    parameter int unsigned addr_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] mem_rdata,
    input  logic                 mem_ready,
    input  logic                 alu_zero_flag,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [addr_size-1:0] mem_addr,
    output logic [op_size-1:0]   alu_sel,
    output logic [2:0]           rf_src1,
    output logic [2:0]           rf_src2,
    output logic [2:0]           rf_dst,
    output logic                 rf_we,
    output logic                 rf_wsel,
    output logic [addr_size-1:0] pc,
    output logic                 halted,
    output logic                 illegal_op
);

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_NOT  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_XNOR = 5'b00111;
    localparam logic [4:0] OP_NAND = 5'b01000;
    localparam logic [4:0] OP_NOR  = 5'b01001;
    localparam logic [4:0] OP_RD   = 5'b01010;
    localparam logic [4:0] OP_WR   = 5'b01011;
    localparam logic [4:0] OP_BR   = 5'b01100;
    localparam logic [4:0] OP_BRZ  = 5'b01101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t               state;
    logic [word_size-1:0] ir;
    logic                 zero_reg;

    logic [4:0] f_opcode;
    logic [2:0] f_dst;
    logic [2:0] f_src1;
    logic [2:0] f_src2;
    logic [7:0] f_addr;

    // Instruction field extraction from the held instruction word
    assign f_opcode = ir[15:11];
    assign f_dst    = ir[10:8];
    assign f_src1   = ir[7:5];
    assign f_src2   = ir[4:2];
    assign f_addr   = ir[7:0];

    // State, program counter, instruction and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= '0;
            ir         <= '0;
            zero_reg   <= 1'b0;
            halted     <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + addr_size'(1);
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (f_opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_OR,
                        OP_XOR, OP_XNOR, OP_NAND, OP_NOR: state <= ST_EXEC;
                        OP_RD:  state <= ST_MEM_RD;
                        OP_WR:  state <= ST_MEM_WR;
                        OP_NOP: state <= ST_FETCH;
                        OP_BR: begin
                            pc    <= addr_size'(f_addr);
                            state <= ST_FETCH;
                        end
                        OP_BRZ: begin
                            if (zero_reg) begin
                                pc <= addr_size'(f_addr);
                            end
                            state <= ST_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end
                        default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            illegal_op <= 1'b1;
                            halted     <= 1'b1;
                            state      <= ST_HALT;
`else
                            state <= ST_FETCH;
`endif
                        end
                    endcase
                end
                ST_EXEC: begin
                    zero_reg <= alu_zero_flag;
                    state    <= ST_FETCH;
                end
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        state <= ST_FETCH;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ready) begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Datapath/memory strobes decoded from the registered state; the load write-back
    // strobe follows mem_ready in the completing cycle, and reset masks everything at once.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc;
        alu_sel  = op_size'(OP_NOP);
        rf_src1  = 3'd0;
        rf_src2  = 3'd0;
        rf_dst   = 3'd0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                end
                ST_EXEC: begin
                    alu_sel = op_size'(f_opcode);
                    rf_src1 = f_src1;
                    rf_src2 = f_src2;
                    rf_dst  = f_dst;
                    rf_we   = 1'b1;
                end
                ST_MEM_RD: begin
                    mem_req  = 1'b1;
                    mem_addr = addr_size'(f_addr);
                    rf_dst   = f_dst;
                    rf_we    = mem_ready;
                    rf_wsel  = mem_ready;
                end
                ST_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = addr_size'(f_addr);
                    rf_src1  = f_dst;
                end
                default: ;
            endcase
        end
    end

endmodule
